// File: rtl/instr_fetch.sv
// instr_fetch: fetch unit with a single-outstanding memory request and an instruction queue.
// Define IFETCH_PREFETCH_EN for a QDEPTH-entry prefetch queue; otherwise the queue holds one word.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);

`ifdef IFETCH_PREFETCH_EN
    localparam int DEPTH = QDEPTH;
`else
    // QDEPTH has no effect without prefetch
    localparam int DEPTH = (QDEPTH > 0) ? 1 : 1;
`endif
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t        state, state_nx;
    logic [15:0]   addr, addr_nx;
    logic [15:0]   target, target_nx;
    logic [15:0]   qdata [DEPTH];
    logic [15:0]   qpc   [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [CW-1:0] left;
    logic          push, pop;
    logic          room_issue, room_more;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + PW'(1);
    endfunction

    assign pop        = (count != '0) && inst_ready;
    assign push       = (state == REQ) && imem_ack && !redirect;
    assign left       = count - CW'(pop);
    // a request reserves its slot, so issue only if a slot is free after the pop
    assign room_issue = left < DEPTH_C;
    // after pushing the returning word, is there still a slot to reserve
    assign room_more  = left < (DEPTH_C - CW'(1));

    // fetch state, address and pending redirect target
    // the register resets to REQ so the first fetch leaves the cycle Reset falls;
    // outputs are masked while Reset is high, so the block looks idle meanwhile
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= REQ;
            addr   <= RESET_PC;
            target <= RESET_PC;
        end else begin
            state  <= state_nx;
            addr   <= addr_nx;
            target <= target_nx;
        end
    end

    // next-state, next fetch address and drop bookkeeping
    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        target_nx = target;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    state_nx = REQ;
                    addr_nx  = redirect_pc;
                end else if (room_issue) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (redirect && imem_ack) begin
                    addr_nx = redirect_pc;
                end else if (redirect) begin
                    state_nx  = DROP;
                    target_nx = redirect_pc;
                end else if (imem_ack) begin
                    addr_nx  = addr + 16'd1;
                    state_nx = room_more ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect) target_nx = redirect_pc;
                if (imem_ack) begin
                    state_nx = REQ;
                    addr_nx  = redirect ? redirect_pc : target;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // instruction queue: push returning words, pop to decode, flush on redirect
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qdata[i] <= '0;
                qpc[i]   <= '0;
            end
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                qdata[tail] <= imem_data;
                qpc[tail]   <= addr;
                tail        <= nxt(tail);
            end
            if (pop) head <= nxt(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign imem_req   = !Reset && (state != IDLE);
    assign imem_addr  = Reset ? RESET_PC : addr;
    assign inst_valid = !Reset && (count != '0);
    assign inst       = Reset ? '0 : qdata[head];
    assign inst_pc    = Reset ? '0 : qpc[head];

endmodule
